// File: rtl/band_doa_pkg.sv
// Shared types, default geometry and saturating arithmetic helpers for the
// DOA front-end blocks.
package band_doa_pkg;

  localparam int DEF_VECTOR_LEN = 64;
  localparam int DEF_BANDS      = 4;
  localparam int CH_PER_BAND    = DEF_VECTOR_LEN / DEF_BANDS;
  localparam int BAND_W         = $clog2(DEF_BANDS);
  localparam int CH_W           = $clog2(DEF_VECTOR_LEN);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} drain_state_t;

  // Clamp v to a signed w-bit range; sat flags a clamp.
  function automatic longint sat_resize(input longint v, input int w, output logic sat);
    longint hi, lo;
    hi  = (longint'(1) <<< (w - 1)) - longint'(1);
    lo  = -hi - longint'(1);
    sat = 1'b0;
    sat_resize = v;
    if (v > hi) begin
      sat = 1'b1;
      sat_resize = hi;
    end else if (v < lo) begin
      sat = 1'b1;
      sat_resize = lo;
    end
  endfunction

  // Scale by 2^sh; a right shift floors (rounds toward -inf).
  function automatic longint scale_floor(input longint v, input int sh);
    scale_floor = (sh >= 0) ? (v <<< sh) : (v >>> (-sh));
  endfunction

  // Saturating add into a signed w-bit result.
  function automatic longint sat_add(input longint a, input longint b, input int w,
                                     output logic sat);
    sat_add = sat_resize(a + b, w, sat);
  endfunction

endpackage

// File: rtl/xcorr_products.sv
// Per-sample auto/cross products, scaled and saturated to the accumulator
// input format, followed by PRE_ACC_DELAY register stages. A tag rides along.
module xcorr_products import band_doa_pkg::*; #(
  parameter int DIN_WIDTH     = 16,
  parameter int DIN_POINT     = 14,
  parameter int PRE_ACC_SHIFT = 2,
  parameter int PRE_ACC_DELAY = 2,
  parameter int ACC_WIDTH     = 20,
  parameter int ACC_POINT     = 16,
  parameter int TAG_W         = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  input  logic signed [DIN_WIDTH-1:0]       re1,
  input  logic signed [DIN_WIDTH-1:0]       im1,
  input  logic signed [DIN_WIDTH-1:0]       re2,
  input  logic signed [DIN_WIDTH-1:0]       im2,
  input  logic [TAG_W-1:0]                  in_tag,
  output logic                              out_valid,
  output logic                              out_sat,
  output logic [3:0][ACC_WIDTH-1:0]         out_p,
  output logic [TAG_W-1:0]                  out_tag
);
  localparam int STAGES = PRE_ACC_DELAY + 1;
  // net shift from 2*DIN_POINT fractional bits (plus pre-shift) to ACC_POINT
  localparam int NET_SH = PRE_ACC_SHIFT + ACC_POINT - 2 * DIN_POINT;

  logic signed [DIN_WIDTH-1:0]         re1_q, im1_q, re2_q, im2_q;
  logic [STAGES:0]                     vld_pipe;
  logic [STAGES:0][TAG_W-1:0]          tag_pipe;
  logic [STAGES:1][3:0][ACC_WIDTH-1:0] p_pipe;
  logic [STAGES:1]                     sat_pipe;
  longint                              raw [4];
  logic [3:0][ACC_WIDTH-1:0]           prod_n;
  logic                                sat_n, s;

  // Full-precision products, then floor-scale and clamp each one.
  always_comb begin
    raw[0] = longint'(re1_q) * longint'(re1_q) + longint'(im1_q) * longint'(im1_q);
    raw[1] = longint'(re2_q) * longint'(re2_q) + longint'(im2_q) * longint'(im2_q);
    raw[2] = longint'(re1_q) * longint'(re2_q) + longint'(im1_q) * longint'(im2_q);
    raw[3] = longint'(im1_q) * longint'(re2_q) - longint'(re1_q) * longint'(im2_q);
    sat_n  = 1'b0;
    s      = 1'b0;
    prod_n = '0;
    for (int k = 0; k < 4; k++) begin
      prod_n[k] = ACC_WIDTH'(sat_resize(scale_floor(raw[k], NET_SH), ACC_WIDTH, s));
      sat_n     = sat_n | s;
    end
  end

  // Input capture, product register and delay line; flush kills samples in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      re1_q    <= '0;
      im1_q    <= '0;
      re2_q    <= '0;
      im2_q    <= '0;
      vld_pipe <= '0;
      tag_pipe <= '0;
      p_pipe   <= '0;
      sat_pipe <= '0;
    end else begin
      re1_q       <= re1;
      im1_q       <= im1;
      re2_q       <= re2;
      im2_q       <= im2;
      vld_pipe[0] <= in_valid;
      tag_pipe[0] <= in_tag;
      vld_pipe[1] <= vld_pipe[0] & ~flush;
      tag_pipe[1] <= tag_pipe[0];
      p_pipe[1]   <= prod_n;
      sat_pipe[1] <= sat_n;
      for (int i = 2; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1] & ~flush;
        tag_pipe[i] <= tag_pipe[i-1];
        p_pipe[i]   <= p_pipe[i-1];
        sat_pipe[i] <= sat_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_sat   = sat_pipe[STAGES];
  assign out_p     = p_pipe[STAGES];
  assign out_tag   = tag_pipe[STAGES];

endmodule

// File: rtl/band_xcorr_acc.sv
// Two-antenna multi-band correlation accumulator: per-band r11/r22/r12 sums
// over a programmable frame count, double-buffered and drained one band per beat.
module band_xcorr_acc import band_doa_pkg::*; #(
  parameter int DIN_WIDTH       = 16,
  parameter int DIN_POINT       = 14,
  parameter int VECTOR_LEN      = DEF_VECTOR_LEN,
  parameter int BANDS           = DEF_BANDS,
  parameter int PRE_ACC_SHIFT   = 2,
  parameter int PRE_ACC_DELAY   = 2,
  parameter int ACC_WIDTH       = 20,
  parameter int ACC_POINT       = 16,
  parameter int DOUT_WIDTH      = 32,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [DIN_WIDTH-1:0] din1_re,
  input  logic signed [DIN_WIDTH-1:0] din1_im,
  input  logic signed [DIN_WIDTH-1:0] din2_re,
  input  logic signed [DIN_WIDTH-1:0] din2_im,
  input  logic                        din_valid,
  input  logic                        new_acc,
  input  logic [FRAME_CNT_WIDTH-1:0]  acc_len,
  output logic [DOUT_WIDTH-1:0]       r11,
  output logic [DOUT_WIDTH-1:0]       r22,
  output logic [DOUT_WIDTH-1:0]       r12_re,
  output logic [DOUT_WIDTH-1:0]       r12_im,
  output logic [$clog2(BANDS)-1:0]    band_number,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        dout_last,
  output logic                        ovf,
  output logic                        sat
);
  localparam int CW = $clog2(VECTOR_LEN);
  localparam int BW = $clog2(BANDS);
  localparam int SH = $clog2(VECTOR_LEN / BANDS);
  localparam int FW = FRAME_CNT_WIDTH;

  logic [CW-1:0]                         ch, ch_e;
  logic [FW-1:0]                         frame, frame_e, len_m1, len_e, len_req;
  logic                                  ch_last, is_last;
  logic [BW:0]                           in_tag, ptag;
  logic                                  pv, psat, take, asat, s, dump_pend;
  logic [3:0][ACC_WIDTH-1:0]             pp;
  logic [BW-1:0]                         pb, idx;
  logic [BANDS-1:0][3:0][DOUT_WIDTH-1:0] acc, obuf;
  logic [3:0][DOUT_WIDTH-1:0]            sum_n, dword;
  logic [BANDS-1:0]                      loaded;
  drain_state_t                          state;

  assign len_req = (acc_len == '0) ? '0 : acc_len - FW'(1);

  // new_acc makes the coincident sample channel 0 of frame 0 with a fresh length.
  always_comb begin
    ch_e    = new_acc ? '0 : ch;
    frame_e = new_acc ? '0 : frame;
    len_e   = new_acc ? len_req : len_m1;
    ch_last = (ch_e == CW'(VECTOR_LEN - 1));
    is_last = ch_last && (frame_e == len_e);
    in_tag  = {din_valid & is_last, BW'(ch_e >> SH)};
  end

  // Channel / frame counters; acc_len re-sampled on restart and at each dump.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch     <= '0;
      frame  <= '0;
      len_m1 <= '0;
    end else if (din_valid) begin
      ch     <= ch_e + CW'(1);
      frame  <= !ch_last ? frame_e : (is_last ? '0 : frame_e + FW'(1));
      len_m1 <= is_last ? len_req : len_e;
    end else if (new_acc) begin
      ch     <= '0;
      frame  <= '0;
      len_m1 <= len_req;
    end
  end

  xcorr_products #(
    .DIN_WIDTH(DIN_WIDTH), .DIN_POINT(DIN_POINT), .PRE_ACC_SHIFT(PRE_ACC_SHIFT),
    .PRE_ACC_DELAY(PRE_ACC_DELAY), .ACC_WIDTH(ACC_WIDTH), .ACC_POINT(ACC_POINT),
    .TAG_W(BW + 1)
  ) u_prod (
    .clk(clk), .rst_n(rst_n), .flush(new_acc), .in_valid(din_valid),
    .re1(din1_re), .im1(din1_im), .re2(din2_re), .im2(din2_im), .in_tag(in_tag),
    .out_valid(pv), .out_sat(psat), .out_p(pp), .out_tag(ptag)
  );

  assign pb   = ptag[BW-1:0];
  assign take = pv & ~new_acc;

  // First sample of a band loads, later ones add with saturation.
  always_comb begin
    sum_n = '0;
    asat  = 1'b0;
    s     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sum_n[k] = DOUT_WIDTH'(sat_add(loaded[pb] ? longint'($signed(acc[pb][k])) : 64'sd0,
                                     longint'($signed(pp[k])), DOUT_WIDTH, s));
      asat     = asat | s;
    end
  end

  // Accumulator array; the dump's last sample clears the load flags so the
  // next frame loads on the same edge the buffer copies the finished sums.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      loaded    <= '0;
      dump_pend <= 1'b0;
    end else begin
      dump_pend <= take & ptag[BW];
      if (new_acc) begin
        loaded <= '0;
      end else if (take) begin
        acc[pb] <= sum_n;
        if (ptag[BW]) loaded <= '0;
        else          loaded[pb] <= 1'b1;
      end
    end
  end

  // Sticky saturation flag.
  always_ff @(posedge clk) begin
    if (!rst_n)                               sat <= 1'b0;
    else if (new_acc)                         sat <= 1'b0;
    else if ((pv & psat) | (take & asat))     sat <= 1'b1;
  end

  // Output buffer and drain FSM; a dump arriving mid-drain is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      obuf       <= '0;
      dword      <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (new_acc) ovf <= 1'b0;
      case (state)
        IDLE: if (dump_pend) begin
          obuf       <= acc;
          dword      <= acc[0];
          idx        <= '0;
          dout_valid <= 1'b1;
          dout_last  <= (BANDS == 1);
          state      <= DRAIN;
        end
        DRAIN: begin
          if (dump_pend) ovf <= 1'b1;
          if (dout_ready) begin
            if (idx == BW'(BANDS - 1)) begin
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
              state      <= IDLE;
            end else begin
              idx       <= idx + BW'(1);
              dword     <= obuf[idx + BW'(1)];
              dout_last <= ((idx + BW'(1)) == BW'(BANDS - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign r11         = dword[0];
  assign r22         = dword[1];
  assign r12_re      = dword[2];
  assign r12_im      = dword[3];
  assign band_number = idx;

endmodule

// File: tb/tb_band_xcorr_acc.sv
// Scoreboard bench for band_xcorr_acc: stimulus tasks push expected band
// words, a negedge monitor pops and compares them on each accepted beat.
module tb_band_xcorr_acc;
  localparam int DW = 16, OW = 32, BW = 2, NB = 4, VL = 64, CPB = 16;
  localparam int NET_SH = 10;  // 28 frac bits, <<2, down to 16 frac bits

  logic clk = 1'b0, rst_n = 1'b0;
  logic signed [DW-1:0] din1_re = '0, din1_im = '0, din2_re = '0, din2_im = '0;
  logic din_valid = 1'b0, new_acc = 1'b0, dout_ready = 1'b1;
  logic [15:0] acc_len = '0;
  logic [OW-1:0] r11, r22, r12_re, r12_im;
  logic [BW-1:0] band_number;
  logic dout_valid, dout_last, ovf, sat;

  band_xcorr_acc dut (
    .clk(clk), .rst_n(rst_n),
    .din1_re(din1_re), .din1_im(din1_im), .din2_re(din2_re), .din2_im(din2_im),
    .din_valid(din_valid), .new_acc(new_acc), .acc_len(acc_len),
    .r11(r11), .r22(r22), .r12_re(r12_re), .r12_im(r12_im),
    .band_number(band_number), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .ovf(ovf), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {longint r11; longint r22; longint re; longint im; int band;} exp_t;
  exp_t   q[$];
  longint macc [NB][4];
  int     n_vec = 0, n_err = 0, vcyc = 0;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic longint q_prod(input longint v);
    longint t;
    t = v >>> NET_SH;
    if (t > 64'sd524287) t = 64'sd524287;
    else if (t < -64'sd524288) t = -64'sd524288;
    return t;
  endfunction

  function automatic longint q_acc(input longint a, input longint b);
    longint t;
    t = a + b;
    if (t > 64'sd2147483647) t = 64'sd2147483647;
    else if (t < -64'sd2147483648) t = -64'sd2147483648;
    return t;
  endfunction

  task automatic samp(input int pat, input int seed, input int c,
                      output int a, output int b, output int x, output int y);
    case (pat)
      0: begin a = 8192; b = 0; x = 0; y = 8192; end
      1: begin a = -32768; b = -32768; x = 1000; y = -3000; end
      default: begin
        a = c * 400 - 12000 + seed * 1500;
        b = 7000 - c * 150;
        x = ((c * 131 + seed * 17) % 8000) - 4000;
        y = seed * 2500 - c * 60 - 3000;
      end
    endcase
  endtask

  // Drive n back-to-back samples; optionally model them as one dump.
  task automatic feed(input int n, input int pat, input int seed, input bit push,
                      input bit na, input bit stop);
    int a, b, x, y, c, f, bn;
    if (push) foreach (macc[i, j]) macc[i][j] = 0;
    for (int i = 0; i < n; i++) begin
      c = i % VL;
      f = i / VL;
      samp(pat, seed + f, c, a, b, x, y);
      @(posedge clk); #1;
      din1_re = DW'(a); din1_im = DW'(b); din2_re = DW'(x); din2_im = DW'(y);
      din_valid = 1'b1;
      new_acc = na && (i == 0);
      if (push) begin
        bn = c / CPB;
        macc[bn][0] = q_acc(macc[bn][0], q_prod(longint'(a) * a + longint'(b) * b));
        macc[bn][1] = q_acc(macc[bn][1], q_prod(longint'(x) * x + longint'(y) * y));
        macc[bn][2] = q_acc(macc[bn][2], q_prod(longint'(a) * x + longint'(b) * y));
        macc[bn][3] = q_acc(macc[bn][3], q_prod(longint'(b) * x - longint'(a) * y));
      end
    end
    if (stop) begin
      @(posedge clk); #1;
      din_valid = 1'b0;
      new_acc = 1'b0;
    end
    if (push)
      for (int k = 0; k < NB; k++)
        q.push_back('{macc[k][0], macc[k][1], macc[k][2], macc[k][3], k});
  endtask

  task automatic wait_valid(input string tag);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dout_valid) break;
    end
    if (k == 40) chk(tag, 0, 1);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 60 && q.size() > 0; k++) @(negedge clk);
    chk(tag, q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: count valid beats, check holding under backpressure, score accepts.
  logic [OW-1:0] h11, h22, hre, him;
  logic [BW-1:0] hb;
  bit            hold = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && dout_valid) begin
      vcyc++;
      if (hold) begin
        chk("hold_r11", r11, h11);
        chk("hold_r22", r22, h22);
        chk("hold_re", r12_re, hre);
        chk("hold_im", r12_im, him);
        chk("hold_band", band_number, hb);
      end
      if (dout_ready) begin
        hold = 0;
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("r11", $signed(r11), e.r11);
          chk("r22", $signed(r22), e.r22);
          chk("r12_re", $signed(r12_re), e.re);
          chk("r12_im", $signed(r12_im), e.im);
          chk("band", band_number, e.band);
          chk("last", dout_last, (e.band == NB - 1));
        end
      end else begin
        hold = 1;
        h11 = r11; h22 = r22; hre = r12_re; him = r12_im; hb = band_number;
      end
    end else hold = 0;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", dout_valid, 0);
    chk("rst_r11", r11, 0);
    chk("rst_band", band_number, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sat", sat, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // constant tone, 2 frames, ready high
    acc_len = 16'd2; dout_ready = 1'b1; vcyc = 0;
    feed(128, 0, 0, 1, 1, 1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dout_valid) break;
      n++;
    end
    chk("latency", n, 5);
    wait_drain("tone_drain");
    chk("tone_cycles", vcyc, 4);
    chk("tone_sat", sat, 0);

    // product saturation, 1 frame
    acc_len = 16'd1;
    feed(64, 1, 0, 1, 1, 1);
    wait_drain("sat_drain");
    chk("sat_flag", sat, 1);

    // backpressure 0101...
    dout_ready = 1'b0; vcyc = 0;
    feed(64, 2, 1, 1, 1, 1);
    wait_valid("bp_valid");
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1 dout_ready = ~dout_ready;
    end
    dout_ready = 1'b1;
    wait_drain("bp_drain");
    chk("bp_cycles", vcyc, 8);
    chk("bp_ovf", ovf, 0);
    chk("bp_sat", sat, 0);

    // overrun: two dumps while drain stalled
    dout_ready = 1'b0;
    feed(64, 2, 2, 1, 1, 0);
    feed(64, 2, 3, 0, 0, 1);
    repeat (8) @(negedge clk);
    chk("ovr_ovf", ovf, 1);
    chk("ovr_valid", dout_valid, 1);
    chk("ovr_band", band_number, 0);
    @(posedge clk); #1 dout_ready = 1'b1;
    wait_drain("ovr_drain");

    // restart at ch=37 after saturating partial frame
    feed(37, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("pre_sat", sat, 1);
    chk("pre_ovf", ovf, 1);
    vcyc = 0;
    feed(64, 2, 5, 1, 1, 1);
    @(negedge clk);
    chk("na_sat", sat, 0);
    chk("na_ovf", ovf, 0);
    wait_drain("na_drain");
    repeat (10) @(negedge clk);
    chk("na_dumps", vcyc, 4);

    // reset during band 1
    dout_ready = 1'b0;
    feed(64, 2, 7, 1, 1, 1);
    wait_valid("mr_valid");
    @(posedge clk); #1 dout_ready = 1'b1;
    @(posedge clk); #1 dout_ready = 1'b0;
    @(negedge clk);
    chk("mr_band1", band_number, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mr_valid0", dout_valid, 0);
    chk("mr_r11", r11, 0);
    chk("mr_r12_im", r12_im, 0);
    chk("mr_band", band_number, 0);
    chk("mr_last", dout_last, 0);
    dout_ready = 1'b1;
    feed(64, 2, 9, 1, 0, 1);
    wait_drain("mr_drain");

    repeat (10) @(negedge clk);
    chk("q_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
